btn_debounce_fsm: RTL and testbench
===================================

// Module: btn_debounce_fsm
// PURPOSE
//  Consumes the 2-FF-synchronised push-button level and removes contact bounce.
//  Emits clean one-cycle press/release/long-press events and a press-toggled
//  enable used to start/stop ADC acquisition on the DE10-Standard.
//  Sits directly downstream of the button synchroniser, upstream of ADC control.
// PARAMETERS
//  DEB_CYCLES     1_000_000  consecutive stable samples to accept a level change (>=2; 20 ms @ 50 MHz)
//  HOLD_CYCLES    50_000_000 cycles in HELD before long_press fires (>DEB_CYCLES; 1 s @ 50 MHz)
//  BTN_ACTIVE_LOW 1          1: btn_sync=0 means pressed (DE10 KEY); 0: active-high
// PORTS
//  clk          in   1  system clock (PLL output)
//  reset        in   1  asynchronous, active-high reset
//  btn_sync     in   1  synchronised raw button level (bouncing)
//  btn_state    out  1  debounced level, 1 = pressed
//  press_pulse  out  1  one-cycle pulse on accepted press
//  release_pulse out 1  one-cycle pulse on accepted release
//  long_press   out  1  one-cycle pulse when held HOLD_CYCLES
//  acq_enable   out  1  toggles on every press_pulse
// BEHAVIOUR
//  - act = btn_sync ^ BTN_ACTIVE_LOW. All outputs registered.
//  - Reset (async, any time, incl. mid-count): state=IDLE, deb_cnt=0, hold_cnt=0,
//    all outputs 0. First event needs a full DEB_CYCLES window after deassertion.
//  - States: IDLE (released stable), PRESS_WAIT, HELD (pressed stable), RELEASE_WAIT.
//  - IDLE: act=1 -> PRESS_WAIT, deb_cnt=1; else stay.
//  - PRESS_WAIT: act=0 -> IDLE, deb_cnt=0 (bounce rejected, no pulse);
//    act=1 & deb_cnt<DEB_CYCLES-1 -> deb_cnt++;
//    act=1 & deb_cnt==DEB_CYCLES-1 -> HELD, press_pulse=1, btn_state=1,
//    acq_enable<=~acq_enable, deb_cnt=0, hold_cnt=0.
//  - Latency: DEB_CYCLES active samples at edges E0..E0+DEB_CYCLES-1 -> press_pulse
//    high in the cycle after edge E0+DEB_CYCLES-1. Release is symmetric.
//  - HELD: act=0 -> RELEASE_WAIT, deb_cnt=1. Else hold_cnt++ (saturating);
//    long_press=1 for exactly one cycle when hold_cnt reaches HOLD_CYCLES-1; once per press.
//  - RELEASE_WAIT: act=1 -> HELD, deb_cnt=0, hold_cnt retained (not cleared, frozen
//    while in RELEASE_WAIT); act=0 & deb_cnt==DEB_CYCLES-1 -> IDLE, release_pulse=1,
//    btn_state=0, hold_cnt=0; else deb_cnt++.
//  - press_pulse/release_pulse/long_press are never high in the same cycle;
//    long_press can never follow release_pulse within the same press.
//  - Counter widths: $clog2(DEB_CYCLES), $clog2(HOLD_CYCLES+1); no wrap, hold_cnt saturates.
//  - Illegal state encoding -> IDLE next cycle, outputs 0.
// STRUCTURE
//  - Shared package btn_pkg: 2-bit state encoding (IDLE=0, PRESS_WAIT=1, HELD=2,
//    RELEASE_WAIT=3), default timing constants for 50 MHz (DEB 20 ms, HOLD 1 s).
//  - One sub-module: sat_counter (clear, enable, saturate at MAX, at_max flag),
//    instantiated twice (deb_cnt, hold_cnt). FSM and output regs in this module.
// TESTING (sim with DEB_CYCLES=4, HOLD_CYCLES=10, BTN_ACTIVE_LOW=1)
//  1 reset high, btn_sync=1 -> all outputs 0; deassert, hold 20 cycles -> no pulses.
//  2 btn_sync=0 for 4 edges -> press_pulse one cycle after 4th edge, btn_state=1, acq_enable=1.
//  3 btn_sync=0,0,0,1 then 1 -> no press_pulse, state back to IDLE, counts restart.
//  4 hold pressed 4+10 cycles -> one long_press pulse; keep held 20 more -> no second pulse.
//  5 release with bounce 1,0,1,1,1,1 -> one release_pulse after 4 stable highs; 2nd press -> acq_enable=0.
//  6 assert reset at deb_cnt=2 in PRESS_WAIT -> outputs 0 immediately (async), IDLE after release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: state encoding and
// default 50 MHz timing constants.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } btn_state_e;

    // 20 ms debounce window and 1 s long-press threshold at 50 MHz.
    localparam int unsigned DebCyclesDefault  = 1_000_000;
    localparam int unsigned HoldCyclesDefault = 50_000_000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at MaxVal. clear together with enable restarts the
// count at 1 so a new window can begin on the same sample that opened it.
module sat_counter #(
    parameter int unsigned Width  = 8,
    parameter int unsigned MaxVal = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [Width-1:0] count,
    output logic             at_max
);

    localparam logic [Width-1:0] MaxCnt = Width'(MaxVal);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = enable ? Width'(1) : '0;
        end else if (enable && (count_q != MaxCnt)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MaxCnt);

endmodule

// File: rtl/btn_debounce_fsm.sv
// Push-button debouncer: accepts a level change after DEB_CYCLES stable samples
// and emits registered press/release/long-press pulses plus a press-toggled enable.
module btn_debounce_fsm
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = DebCyclesDefault,
    parameter int unsigned HOLD_CYCLES    = HoldCyclesDefault,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_sync,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic acq_enable
);

    localparam int unsigned DebW  = $clog2(DEB_CYCLES);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldFire = HoldW'(HOLD_CYCLES - 1);

    btn_state_e       state_q;
    logic             act;
    logic             deb_clear, deb_en, deb_done;
    logic             hold_clear, hold_en, hold_at_max;
    logic [DebW-1:0]  deb_cnt;
    logic [HoldW-1:0] hold_cnt;
    logic             unused_deb_cnt;

    assign act            = btn_sync ^ BTN_ACTIVE_LOW;
    assign unused_deb_cnt = ^deb_cnt;

    sat_counter #(
        .Width  (DebW),
        .MaxVal (DEB_CYCLES - 1)
    ) u_deb_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (deb_clear),
        .enable (deb_en),
        .count  (deb_cnt),
        .at_max (deb_done)
    );

    sat_counter #(
        .Width  (HoldW),
        .MaxVal (HOLD_CYCLES)
    ) u_hold_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (hold_clear),
        .enable (hold_en),
        .count  (hold_cnt),
        .at_max (hold_at_max)
    );

    // Counter control mirrors the FSM transitions below; hold_cnt is frozen in
    // StReleaseWait so a release bounce cannot re-arm long_press.
    always_comb begin
        deb_clear  = 1'b1;
        deb_en     = 1'b0;
        hold_clear = 1'b0;
        hold_en    = 1'b0;
        case (state_q)
            StIdle: begin
                deb_en     = act;
                hold_clear = 1'b1;
            end
            StPressWait: begin
                if (act && !deb_done) begin
                    deb_clear = 1'b0;
                    deb_en    = 1'b1;
                end
                hold_clear = act && deb_done;
            end
            StHeld: begin
                deb_en  = !act;
                hold_en = act && !hold_at_max;
            end
            StReleaseWait: begin
                if (!act && !deb_done) begin
                    deb_clear = 1'b0;
                    deb_en    = 1'b1;
                end
                hold_clear = !act && deb_done;
            end
            default: hold_clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            btn_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            acq_enable    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (act) state_q <= StPressWait;
                end
                StPressWait: begin
                    if (!act) begin
                        state_q <= StIdle;
                    end else if (deb_done) begin
                        state_q     <= StHeld;
                        press_pulse <= 1'b1;
                        btn_state   <= 1'b1;
                        acq_enable  <= ~acq_enable;
                    end
                end
                StHeld: begin
                    if (!act) begin
                        state_q <= StReleaseWait;
                    end else if (hold_cnt == HoldFire) begin
                        long_press <= 1'b1;
                    end
                end
                StReleaseWait: begin
                    if (act) begin
                        state_q <= StHeld;
                    end else if (deb_done) begin
                        state_q       <= StIdle;
                        release_pulse <= 1'b1;
                        btn_state     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    btn_state  <= 1'b0;
                    acq_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce_fsm.sv
// Directed bench for btn_debounce_fsm with DEB_CYCLES=4, HOLD_CYCLES=10, active-low button.
module tb_btn_debounce_fsm;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic btn_sync = 1'b1;
    logic btn_state, press_pulse, release_pulse, long_press, acq_enable;
    logic [4:0] outs;

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    always #5 clk = ~clk;

    btn_debounce_fsm #(
        .DEB_CYCLES     (4),
        .HOLD_CYCLES    (10),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_sync      (btn_sync),
        .btn_state     (btn_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .acq_enable    (acq_enable)
    );

    // {btn_state, press_pulse, release_pulse, long_press, acq_enable}
    assign outs = {btn_state, press_pulse, release_pulse, long_press, acq_enable};

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    // Drive one sample, let one edge pass, then compare outputs.
    task automatic cyc(input logic b, input logic [4:0] exp, input string tag);
        btn_sync = b;
        @(posedge clk);
        #1;
        check_eq(tag, outs, exp);
    endtask

    task automatic run(input logic b, input int n, input logic [4:0] exp, input string tag);
        for (int i = 0; i < n; i++) cyc(b, exp, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with button released; outputs quiet before and after deassertion.
        #1 reset = 1'b1;
        #2 check_eq("reset", outs, 5'b00000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run(1'b1, 20, 5'b00000, "idle_quiet");

        // Short bounce of three active samples is rejected.
        run(1'b0, 3, 5'b00000, "bounce_pw");
        cyc(1'b1, 5'b00000, "bounce_reject");
        cyc(1'b1, 5'b00000, "bounce_idle");

        // Clean press: pulse appears after the 4th active edge.
        run(1'b0, 3, 5'b00000, "press_deb");
        cyc(1'b0, 5'b11001, "press_pulse");

        // Long press fires once on the 10th held cycle, never again this press.
        run(1'b0, 9, 5'b10001, "held_pre_long");
        cyc(1'b0, 5'b10011, "long_press");
        run(1'b0, 20, 5'b10001, "held_no_relong");

        // Release with bounce 1,0,1,1,1,1.
        cyc(1'b1, 5'b10001, "rel_bounce1");
        cyc(1'b0, 5'b10001, "rel_bounce2");
        run(1'b1, 3, 5'b10001, "rel_deb");
        cyc(1'b1, 5'b00101, "release_pulse");
        cyc(1'b1, 5'b00001, "idle_after_rel");

        // Second short press toggles acq_enable off; no long press.
        run(1'b0, 3, 5'b00001, "press2_deb");
        cyc(1'b0, 5'b11000, "press2_acq_off");
        run(1'b1, 3, 5'b10000, "rel2_deb");
        cyc(1'b1, 5'b00100, "release2_pulse");

        // Third press: long press re-arms after a full release.
        run(1'b0, 3, 5'b00000, "press3_deb");
        cyc(1'b0, 5'b11001, "press3_pulse");
        run(1'b0, 9, 5'b10001, "held3_pre_long");
        cyc(1'b0, 5'b10011, "long_press3");
        run(1'b1, 3, 5'b10001, "rel3_deb");
        cyc(1'b1, 5'b00101, "release3_pulse");

        // Async reset mid-debounce (deb_cnt=2 in PRESS_WAIT).
        cyc(1'b0, 5'b00001, "pw_deb1");
        cyc(1'b0, 5'b00001, "pw_deb2");
        #2 reset = 1'b1;
        #1 check_eq("async_reset", outs, 5'b00000);
        run(1'b0, 2, 5'b00000, "reset_held");
        reset = 1'b0;
        run(1'b1, 3, 5'b00000, "post_reset_idle");

        // First event after reset needs a full window.
        run(1'b0, 3, 5'b00000, "post_reset_deb");
        cyc(1'b0, 5'b11001, "post_reset_press");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
